// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into 32-bit
// word writes and holds the core in reset until the image is in. Optional checksum: IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_waddr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_rst_n_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        DONE,
`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM,
`endif
        ERR
    } state_t;

    localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

    state_t              state_reg;
    logic                ready_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   waddr_reg;
    logic [31:0]         wdata_reg;
    logic                done_reg;
    logic                err_reg;
    logic [15:0]         cnt_reg;
    logic [1:0]          byte_cnt_reg;
    logic [ADDR_W-1:0]   word_idx_reg;
    logic [23:0]         asm_reg;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]          sum_reg;
`endif

    logic        xfer;
    logic        start_ok;
    logic        last_word;
    logic [15:0] hdr_cnt;

    assign xfer      = in_valid_i & ready_reg;
    assign start_ok  = start_i & ((state_reg == IDLE) | (state_reg == DONE) | (state_reg == ERR));
    assign hdr_cnt   = {in_data_i, cnt_reg[7:0]};
    assign last_word = (16'(word_idx_reg) == (cnt_reg - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
            asm_reg      <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            we_reg <= 1'b0;
            if (start_ok) begin
                state_reg    <= HDR0;
                ready_reg    <= 1'b1;
                done_reg     <= 1'b0;
                err_reg      <= 1'b0;
                cnt_reg      <= '0;
                byte_cnt_reg <= '0;
                word_idx_reg <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                sum_reg      <= '0;
`endif
            end else begin
                case (state_reg)
                    HDR0: if (xfer) begin
                        cnt_reg[7:0] <= in_data_i;
                        state_reg    <= HDR1;
                    end
                    HDR1: if (xfer) begin
                        cnt_reg[15:8] <= in_data_i;
                        if (hdr_cnt == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                            state_reg <= CKSUM;
`else
                            state_reg <= DONE;
                            ready_reg <= 1'b0;
`endif
                        end else if (hdr_cnt > DEPTH_16) begin
                            state_reg <= ERR;
                            ready_reg <= 1'b0;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                    DATA: if (xfer) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_reg      <= sum_reg + in_data_i;
`endif
                        case (byte_cnt_reg)
                            2'd0: asm_reg[7:0]   <= in_data_i;
                            2'd1: asm_reg[15:8]  <= in_data_i;
                            2'd2: asm_reg[23:16] <= in_data_i;
                            default: begin
                                // Separate write register lets the next word assemble without a stall.
                                we_reg       <= 1'b1;
                                waddr_reg    <= word_idx_reg;
                                wdata_reg    <= {in_data_i, asm_reg};
                                word_idx_reg <= word_idx_reg + 1'b1;
                                if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                                    state_reg <= CKSUM;
`else
                                    state_reg <= DONE;
                                    ready_reg <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
`ifdef IMEM_LOADER_CKSUM_EN
                    CKSUM: if (xfer) begin
                        ready_reg <= 1'b0;
                        if (in_data_i == sum_reg) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ERR;
                            err_reg   <= 1'b1;
                        end
                    end
`endif
                    // done_o rises one cycle after entering DONE so the final write lands first.
                    DONE: done_reg <= 1'b1;
                    ERR:  ready_reg <= 1'b0;
                    default: begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready_o   = ready_reg;
    assign imem_we_o    = we_reg;
    assign imem_waddr_o = waddr_reg;
    assign imem_wdata_o = wdata_reg;
    assign done_o       = done_reg;
    assign err_o        = err_reg;
    assign cpu_rst_n_o  = done_reg;

endmodule
